// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, colours, the reset board and executor types.
package chess_pkg;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] ROOK   = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] KNIGHT = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  // Square 63 is the leftmost nibble, square 0 the rightmost.
  localparam logic [255:0] INIT_BOARD =
    256'hACBEDBCA_99999999_00000000_00000000_00000000_00000000_11111111_24365342;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_FIXUP, S_DONE} state_e;

  typedef struct packed {
    logic [5:0] src;
    logic [5:0] dst;
    logic [3:0] mov;
    logic [3:0] old;
  } move_t;

endpackage

// File: rtl/special_move_detect.sv
// Combinational classification of a latched move: en passant and castling.
// Castling rook relocation is only reported when CASTLING_EN is defined.
module special_move_detect
  import chess_pkg::*;
(
  input  logic [5:0] src_i,
  input  logic [5:0] dst_i,
  input  logic [3:0] mov_i,
  input  logic [3:0] old_i,
  output logic       ep_o,
  output logic [5:0] ep_sq_o,
  output logic       castle_k_o,
  output logic       castle_q_o,
  output logic [5:0] rook_src_o,
  output logic [5:0] rook_dst_o
);

  always_comb begin
    ep_o    = (mov_i[2:0] == PAWN) && (dst_i[2:0] != src_i[2:0]) && (old_i == 4'h0);
    // The captured pawn sits one rank behind the destination, from the mover's view.
    ep_sq_o = (mov_i[3] == BLACK) ? dst_i + 6'd8 : dst_i - 6'd8;
`ifdef CASTLING_EN
    castle_k_o = (mov_i[2:0] == KING) && (src_i[2:0] == 3'd4) && (dst_i == src_i + 6'd2);
    castle_q_o = (mov_i[2:0] == KING) && (src_i[2:0] == 3'd4) && (dst_i == src_i - 6'd2);
`else
    castle_k_o = 1'b0;
    castle_q_o = 1'b0;
`endif
    rook_src_o = castle_q_o ? src_i - 6'd4 : src_i + 6'd3;
    rook_dst_o = castle_q_o ? src_i - 6'd1 : src_i + 6'd1;
  end

endmodule

// File: rtl/board_executor.sv
// Chess board state holder: executes move instructions and pawn promotions.
// Optional macro CASTLING_EN enables rook relocation on king two-file moves.
module board_executor
  import chess_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         move,
  input  logic [11:0]  instruction,
  input  logic         promote,
  input  logic [2:0]   promoteRow,
  input  logic [2:0]   promotePiece,
  output logic [255:0] boardData,
  output logic         boardReady,
  output logic [3:0]   capturedPiece
);

  state_e           state_q, state_d;
  logic [63:0][3:0] board_q, board_d;
  move_t            mv_q, mv_d;
  logic [3:0]       cap_q, cap_d;
  logic [5:0]       last_q, last_d;
  logic             promote_q;

  logic       ep, castle_k, castle_q;
  logic [5:0] ep_sq, rook_src, rook_dst;
  logic       promo_ok;

  special_move_detect u_smd (
    .src_i      (mv_q.src),
    .dst_i      (mv_q.dst),
    .mov_i      (mv_q.mov),
    .old_i      (mv_q.old),
    .ep_o       (ep),
    .ep_sq_o    (ep_sq),
    .castle_k_o (castle_k),
    .castle_q_o (castle_q),
    .rook_src_o (rook_src),
    .rook_dst_o (rook_dst)
  );

  assign promo_ok = promote_q && !promote && (promoteRow == last_q[2:0]) &&
                    (promotePiece >= ROOK) && (promotePiece <= QUEEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      board_q   <= INIT_BOARD;
      mv_q      <= '0;
      cap_q     <= 4'h0;
      last_q    <= 6'd0;
      promote_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      mv_q      <= mv_d;
      cap_q     <= cap_d;
      last_q    <= last_d;
      promote_q <= promote;
    end
  end

  // A promotion commit borrows DONE so boardReady dips for a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (move)          state_d = S_APPLY;
        else if (promo_ok) state_d = S_DONE;
      end
      S_APPLY: state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    board_d = board_q;
    mv_d    = mv_q;
    cap_d   = cap_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (move) begin
          mv_d.src = instruction[11:6];
          mv_d.dst = instruction[5:0];
          mv_d.mov = board_q[instruction[11:6]];
          mv_d.old = board_q[instruction[5:0]];
        end else if (promo_ok) begin
          board_d[last_q] = {board_q[last_q][3], promotePiece};
        end
      end
      S_APPLY: begin
        last_d = mv_q.dst;
        if (mv_q.mov != 4'h0) begin
          board_d[mv_q.src] = 4'h0;
          board_d[mv_q.dst] = mv_q.mov;
          cap_d             = mv_q.old;
        end
      end
      S_FIXUP: begin
        if (mv_q.mov != 4'h0) begin
          if (ep) begin
            cap_d          = board_q[ep_sq];
            board_d[ep_sq] = 4'h0;
          end
          if (castle_k || castle_q) begin
            board_d[rook_dst] = board_q[rook_src];
            board_d[rook_src] = 4'h0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    boardReady    = (state_q == S_IDLE);
    boardData     = board_q;
    capturedPiece = cap_q;
  end

endmodule

// File: tb/tb_board_executor.sv
// Directed bench for board_executor against an array-based chess move model.
module tb_board_executor;

  logic         clk = 1'b0;
  logic         reset, move, promote;
  logic [11:0]  instruction;
  logic [2:0]   promoteRow, promotePiece;
  logic [255:0] boardData;
  logic         boardReady;
  logic [3:0]   capturedPiece;

  localparam logic [255:0] INIT =
    256'hACBEDBCA_99999999_00000000_00000000_00000000_00000000_11111111_24365342;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int mb[64];
  int mcap, mlast;
  int lows;

  board_executor dut (
    .clk          (clk),
    .reset        (reset),
    .move         (move),
    .instruction  (instruction),
    .promote      (promote),
    .promoteRow   (promoteRow),
    .promotePiece (promotePiece),
    .boardData    (boardData),
    .boardReady   (boardReady),
    .capturedPiece(capturedPiece)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_board();
    logic [255:0] r;
    for (int i = 0; i < 64; i++) r[i*4 +: 4] = mb[i][3:0];
    return r;
  endfunction

  function automatic logic [3:0] sq(input int s);
    return boardData[s*4 +: 4];
  endfunction

  task automatic model_reset();
    logic [255:0] ib;
    ib = INIT;
    for (int i = 0; i < 64; i++) mb[i] = int'(ib[i*4 +: 4]);
    mcap  = 0;
    mlast = 0;
  endtask

  task automatic model_move(input int s, input int d);
    int mov, old, vic;
    mov   = mb[s];
    old   = mb[d];
    mlast = d;
    if (mov == 0) return;
    mb[d] = mov;
    mb[s] = 0;
    mcap  = old;
    if ((mov % 8) == 1 && (d % 8) != (s % 8) && old == 0) begin
      vic     = (mov >= 8) ? d + 8 : d - 8;
      mcap    = mb[vic];
      mb[vic] = 0;
    end
`ifdef CASTLING_EN
    if ((mov % 8) == 6 && (s % 8) == 4 && d == s + 2) begin
      mb[s+1] = mb[s+3];
      mb[s+3] = 0;
    end
    if ((mov % 8) == 6 && (s % 8) == 4 && d == s - 2) begin
      mb[s-1] = mb[s-4];
      mb[s-4] = 0;
    end
`endif
  endtask

  task automatic model_promo(input int row, input int piece);
    if (row == (mlast % 8) && piece >= 2 && piece <= 5)
      mb[mlast] = (mb[mlast] / 8) * 8 + piece;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (boardReady) break;
      n++;
    end
  endtask

  task automatic do_move(input int s, input int d, input string nm);
    int n;
    @(posedge clk); #1;
    move = 1'b1;
    instruction = {s[5:0], d[5:0]};
    @(posedge clk); #1;
    move = 1'b0;
    model_move(s, d);
    wait_ready(n);
    check(nm, n, 3);
  endtask

  task automatic do_promo(input int row, input int piece, input int exp_low, input string nm);
    int n;
    promoteRow   = row[2:0];
    promotePiece = piece[2:0];
    @(posedge clk); #1 promote = 1'b1;
    @(posedge clk); #1 promote = 1'b0;
    @(posedge clk); #1;
    model_promo(row, piece);
    wait_ready(n);
    check(nm, n, exp_low);
  endtask

  // Whenever the executor reports idle, its whole visible state must match the model.
  always @(negedge clk) begin
    if (chk_en && boardReady) begin
      check("board", boardData, model_board());
      check("captured", capturedPiece, mcap[3:0]);
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; move = 1'b0; promote = 1'b0;
    instruction = '0; promoteRow = '0; promotePiece = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_board", boardData, INIT);
    check("rst_ready", boardReady, 1);
    check("rst_cap", capturedPiece, 0);
    chk_en = 1'b1;

    do_move(12, 28, "low_12_28");
    check("sq28", sq(28), 4'h1);
    check("sq12", sq(12), 4'h0);
    check("cap_12_28", capturedPiece, 4'h0);

    do_move(28, 36, "low_28_36");
    do_move(51, 35, "low_51_35");
    do_move(36, 43, "low_ep");
    check("ep_sq43", sq(43), 4'h1);
    check("ep_sq35", sq(35), 4'h0);
    check("ep_sq36", sq(36), 4'h0);
    check("ep_cap", capturedPiece, 4'h9);

    do_move(43, 52, "low_43_52");
    do_move(52, 60, "low_52_60");
    check("cap_king", capturedPiece, 4'hE);
    check("sq60_pawn", sq(60), 4'h1);

    do_promo(3, 5, 0, "promo_badrow");
    check("sq60_badrow", sq(60), 4'h1);
    do_promo(4, 6, 0, "promo_badpiece");
    do_promo(4, 5, 1, "promo_ok");
    check("sq60_queen", sq(60), 4'h5);

    do_move(5, 20, "low_5_20");
    do_move(6, 21, "low_6_21");
    do_move(4, 6, "low_castle");
    check("castle_sq6", sq(6), 4'h6);
    check("castle_sq4", sq(4), 4'h0);
`ifdef CASTLING_EN
    check("castle_sq5", sq(5), 4'h2);
    check("castle_sq7", sq(7), 4'h0);
`else
    check("castle_sq5", sq(5), 4'h0);
    check("castle_sq7", sq(7), 4'h2);
`endif

    // Move and promote falling edge together: the move wins.
    promoteRow = 3'd6; promotePiece = 3'd5;
    @(posedge clk); #1 promote = 1'b1;
    @(posedge clk); #1;
    promote = 1'b0; move = 1'b1; instruction = {6'd13, 6'd21};
    @(posedge clk); #1 move = 1'b0;
    model_move(13, 21);
    wait_ready(lows);
    check("low_simul", lows, 3);
    check("simul_sq6", sq(6), 4'h6);
    check("simul_cap", capturedPiece, 4'h4);

    do_move(30, 31, "low_empty");
    check("empty_cap", capturedPiece, 4'h4);

    // Second request lands on the FIXUP edge and must be dropped.
    @(posedge clk); #1 move = 1'b1; instruction = {6'd8, 6'd16};
    @(posedge clk); #1 move = 1'b0;
    model_move(8, 16);
    @(posedge clk); #1 move = 1'b1; instruction = {6'd9, 6'd17};
    @(posedge clk); #1 move = 1'b0;
    wait_ready(lows);
    check("low_ignored", lows, 1);
    check("ign_sq17", sq(17), 4'h0);
    check("ign_sq9", sq(9), 4'h1);
    repeat (3) @(negedge clk);

    // Reset landing on the APPLY edge.
    chk_en = 1'b0;
    @(posedge clk); #1 move = 1'b1; instruction = {6'd1, 6'd18};
    @(posedge clk); #1 move = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("midrst_board", boardData, INIT);
    check("midrst_ready", boardReady, 1);
    check("midrst_cap", capturedPiece, 0);
    model_reset();
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_executor.md
BOARD_EXECUTOR -- requirements
Module: board_executor

Interface
REQ-001 Parameters SHALL be none; all sizing is fixed by the 64-square, 4-bit-per-square board encoding.
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 move  input  1  one-cycle request to execute instruction.
REQ-005 instruction  input  12  {startSquare[11:6], targetSquare[5:0]}, sampled when move=1.
REQ-006 promote  input  1  level; high while a promotion is pending, falling edge commits promotePiece.
REQ-007 promoteRow  input  3  file (square%8) of the promoting pawn.
REQ-008 promotePiece  input  3  piece type to place on promotion commit.
REQ-009 boardData  output  256  board; square s at [s*4+:4], bit 3 color (0 white, 1 black), bits 2:0 type (0 empty, 1 PAWN, 2 ROOK, 3 BISHOP, 4 KNIGHT, 5 QUEEN, 6 KING).
REQ-010 boardReady  output  1  high when idle and boardData is stable.
REQ-011 capturedPiece  output  4  nibble removed by the last executed move (0 if none).

Function
REQ-012 FSM states SHALL be IDLE, APPLY, FIXUP, DONE; IDLE->APPLY on move=1, APPLY->FIXUP, FIXUP->DONE, DONE->IDLE unconditionally.
REQ-013 On the edge sampling move=1 in IDLE: latch src, dst, moving nibble and dst nibble; boardReady<=0.
REQ-014 APPLY: dst<=moving nibble, src<=0, capturedPiece<=old dst nibble; if src nibble is 0, board and capturedPiece SHALL be unchanged.
REQ-015 FIXUP en passant: moving type PAWN, dst%8!=src%8, old dst empty -> clear square (dst-8 if white, dst+8 if black); capturedPiece<=that nibble.
REQ-016 FIXUP castling (see REQ-027): moving type KING, src%8=4, dst=src+2 -> rook src+3 to src+1; dst=src-2 -> rook src-4 to src-1.
REQ-017 DONE: boardReady<=1; boardReady SHALL be low for exactly 3 cycles per move.
REQ-018 move=1 outside IDLE SHALL be ignored.
REQ-019 Promotion commit: falling edge of promote (registered compare) in IDLE, promoteRow==lastDst%8, promotePiece in 2..5 -> lastDst<={color bit of lastDst, promotePiece}; boardReady low exactly 1 cycle; otherwise no change, boardReady stays high.
REQ-020 lastDst SHALL be the dst of the most recent executed move; reset value 0.
REQ-021 Simultaneous move=1 and promote falling edge in IDLE: move executes, promote event discarded.
REQ-022 No legality checking; the executor SHALL apply any instruction given.

Reset
REQ-023 Reset SHALL force IDLE, boardReady=1, capturedPiece=0, lastDst=0, promote edge register=0.
REQ-024 Reset SHALL load initial board: squares 0-7 white R N B Q K B N R (files 0-7), 8-15 white PAWN, 16-47 empty, 48-55 black PAWN, 56-63 black R N B Q K B N R.
REQ-025 Reset mid-operation SHALL abandon the move; initial board and boardReady=1 visible after that edge.
REQ-026 Reset SHALL take priority over move and promote.

Configuration
REQ-027 Macro CASTLING_EN: defined -> REQ-016 rook relocation active; undefined -> king two-file move is a plain move, rook untouched, FIXUP performs only en passant.

Structure
REQ-028 Shared package chess_pkg SHALL hold piece-type codes, WHITE/BLACK constants, and the 256-bit INIT_BOARD constant.
REQ-029 Sub-module special_move_detect (combinational: src, dst, moving nibble, dst nibble -> en passant flag, castle flags, rook src/dst) SHALL be instantiated once.

Verification
REQ-030 Reset, move=1 instruction={12,28} -> boardReady low 3 cycles, square 28=0x1, 12=0, capturedPiece=0.
REQ-031 White pawn on 36, black pawn moved 51->35, then move {36,43} -> 43=0x1, 35=0, 36=0, capturedPiece=0x9.
REQ-032 CASTLING_EN defined, squares 5,6 cleared, move {4,6} -> 6=0x6, 5=0x2, 4=0, 7=0; undefined -> 7 stays 0x2, 5=0.
REQ-033 White pawn moved to 60 (black king overwritten, capturedPiece=0xE), promoteRow=4, promotePiece=5, promote 1->0 -> 60=0x5, boardReady low 1 cycle; promoteRow=3 -> no change.
REQ-034 Reset asserted during APPLY of {1,18} -> next cycle board equals INIT_BOARD, boardReady=1; move=1 during FIXUP -> ignored.
